// File: rtl/pps_gen_pkg.sv
// -----------------------------------------------------------------------------
// pps_gen_pkg
// Shared definitions for the PPS generator:
//   state_t      - generator FSM states (IDLE, WAIT_SYNC, RUN)
//   TRIM_BITS    - width of the signed one-shot period trim
//   clamp_width  - limits a pulse width so that at least one low cycle
//                  remains in every second
// -----------------------------------------------------------------------------
package pps_gen_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int TRIM_BITS = 8;

    // Widths at or beyond the period are cut to period-1 so the output
    // always returns low before the next rising edge.
    function automatic logic [63:0] clamp_width(input logic [63:0] width,
                                                input logic [63:0] period);
        logic [63:0] result;
        if (width >= period) begin
            result = period - 64'd1;
        end else begin
            result = width;
        end
        return result;
    endfunction

endpackage

// File: rtl/pps_period_counter.sv
// -----------------------------------------------------------------------------
// pps_period_counter
// Per-second clock counter with period selection and wrap detection.
//
// Optional feature (macro PPS_GEN_TRIM_EN): a signed trim written via
// trim_wr is held pending and applied, one-shot, to the second that begins
// at the next wrap. Without the macro the period is always CLK_FREQ.
//
// Ports:
//   clk         in   clock
//   rst         in   asynchronous active-high reset
//   enable      in   counter advances (generator is running)
//   load        in   start of the first second (entry into RUN)
//   clear       in   stop request: counter to zero, pending trim dropped
//   trim        in   signed period trim, clocks
//   trim_wr     in   trim write strobe
//   cnt_next    out  counter value after this edge
//   period_next out  period register value after this edge
//   wrap        out  this edge ends the current second
// -----------------------------------------------------------------------------
module pps_period_counter
    import pps_gen_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int CNT_BITS = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        load,
    input  logic                        clear,
    input  logic signed [TRIM_BITS-1:0] trim,
    input  logic                        trim_wr,
    output logic [CNT_BITS-1:0]         cnt_next,
    output logic [CNT_BITS-1:0]         period_next,
    output logic                        wrap
);

    localparam logic [CNT_BITS-1:0] NOMINAL = CNT_BITS'(CLK_FREQ);
    localparam logic [CNT_BITS-1:0] ONE     = CNT_BITS'(1);

    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] period;
    logic [CNT_BITS-1:0] period_after_wrap;

    // A stop on the same edge suppresses the wrap so nothing else advances.
    assign wrap = enable && !clear && (cnt == (period - ONE));

`ifdef PPS_GEN_TRIM_EN
    logic                        trim_pending;
    logic signed [TRIM_BITS-1:0] trim_value;

    // Pending trim: a new write always wins over consumption at a wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trim_pending <= 1'b0;
            trim_value   <= '0;
        end else if (clear) begin
            trim_pending <= 1'b0;
            trim_value   <= trim_value;
        end else if (trim_wr) begin
            trim_pending <= 1'b1;
            trim_value   <= trim;
        end else if (wrap && trim_pending) begin
            trim_pending <= 1'b0;
            trim_value   <= trim_value;
        end else begin
            trim_pending <= trim_pending;
            trim_value   <= trim_value;
        end
    end

    assign period_after_wrap = trim_pending
        ? (NOMINAL + {{(CNT_BITS-TRIM_BITS){trim_value[TRIM_BITS-1]}}, trim_value})
        : NOMINAL;
`else
    logic unused_trim;
    assign unused_trim       = ^{trim, trim_wr};
    assign period_after_wrap = NOMINAL;
`endif

    // Next counter and period values; period only changes at a second boundary.
    always_comb begin
        cnt_next    = cnt;
        period_next = period;
        if (clear) begin
            cnt_next = '0;
        end else if (load) begin
            cnt_next    = '0;
            period_next = NOMINAL;
        end else if (wrap) begin
            cnt_next    = '0;
            period_next = period_after_wrap;
        end else if (enable) begin
            cnt_next = cnt + ONE;
        end else begin
            cnt_next = cnt;
        end
    end

    // Counter and period registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            period <= NOMINAL;
        end else begin
            cnt    <= cnt_next;
            period <= period_next;
        end
    end

endmodule

// File: rtl/pps_gen.sv
// -----------------------------------------------------------------------------
// pps_gen
// Local PPS pulse-train generator. Runs free after start_i, or arms and
// aligns its first edge to sync_i when align_i is high at start. Pulse width
// is programmable and takes effect only at a second boundary.
//
// Optional feature (macro PPS_GEN_TRIM_EN): one-shot signed period trim via
// trim_i / trim_wr_i. Undefined: trim inputs are ignored.
//
// Ports:
//   clk_i        in   clock, all logic in this domain
//   rst_i        in   asynchronous active-high reset
//   start_i      in   one-cycle start request
//   stop_i       in   one-cycle stop request (wins over everything)
//   align_i      in   level, wait for sync_i when starting
//   sync_i       in   one-cycle external PPS flag
//   width_i      in   new pulse width, clocks
//   width_wr_i   in   width write strobe
//   trim_i       in   signed period trim, clocks
//   trim_wr_i    in   trim write strobe
//   pps_o        out  registered PPS pulse
//   pps_flag_o   out  one-cycle flag on each pps rising boundary
//   armed_o      out  waiting for sync_i
//   running_o    out  generating
//   sec_count_o  out  seconds generated since last start
// -----------------------------------------------------------------------------
module pps_gen
    import pps_gen_pkg::*;
#(
    parameter int CLK_FREQ      = 100000000,
    parameter int CNT_BITS      = 32,
    parameter int WIDTH_BITS    = 24,
    parameter int DEFAULT_WIDTH = 10000000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic                        stop_i,
    input  logic                        align_i,
    input  logic                        sync_i,
    input  logic [WIDTH_BITS-1:0]       width_i,
    input  logic                        width_wr_i,
    input  logic signed [TRIM_BITS-1:0] trim_i,
    input  logic                        trim_wr_i,
    output logic                        pps_o,
    output logic                        pps_flag_o,
    output logic                        armed_o,
    output logic                        running_o,
    output logic [31:0]                 sec_count_o
);

    state_t                state;
    state_t                state_next;
    logic [WIDTH_BITS-1:0] width_shadow;
    logic [CNT_BITS-1:0]   width_act;
    logic [CNT_BITS-1:0]   width_new;
    logic [CNT_BITS-1:0]   width_cur;
    logic [CNT_BITS-1:0]   cnt_next;
    logic [CNT_BITS-1:0]   period_next;
    logic                  wrap;
    logic                  load;
    logic                  start_accept;
    logic                  pps_next;

    pps_period_counter #(
        .CLK_FREQ (CLK_FREQ),
        .CNT_BITS (CNT_BITS)
    ) u_counter (
        .clk         (clk_i),
        .rst         (rst_i),
        .enable      (state == RUN),
        .load        (load),
        .clear       (stop_i),
        .trim        (trim_i),
        .trim_wr     (trim_wr_i),
        .cnt_next    (cnt_next),
        .period_next (period_next),
        .wrap        (wrap)
    );

    // Shadow width clamped against the period of the second about to start.
    assign width_new = CNT_BITS'(clamp_width(64'(width_shadow), 64'(period_next)));

    // Next state, boundary events and next pulse level.
    always_comb begin
        state_next = state;
        if (stop_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state_next = align_i ? WAIT_SYNC : RUN;
                    end else begin
                        state_next = IDLE;
                    end
                end
                WAIT_SYNC: begin
                    if (sync_i) begin
                        state_next = RUN;
                    end else begin
                        state_next = WAIT_SYNC;
                    end
                end
                RUN:     state_next = RUN;
                default: state_next = IDLE;
            endcase
        end

        load         = (state != RUN) && (state_next == RUN);
        start_accept = (state == IDLE) && start_i && !stop_i;
        // The width in force for the cycle after this edge.
        width_cur    = (load || wrap) ? width_new : width_act;
        pps_next     = (state_next == RUN) && (cnt_next < width_cur);
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Width registers: shadow loads at once, active width only at boundaries.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            width_shadow <= WIDTH_BITS'(DEFAULT_WIDTH);
            width_act    <= CNT_BITS'(DEFAULT_WIDTH);
        end else begin
            if (width_wr_i) begin
                width_shadow <= width_i;
            end else begin
                width_shadow <= width_shadow;
            end
            if (load || wrap) begin
                width_act <= width_new;
            end else begin
                width_act <= width_act;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pps_o       <= 1'b0;
            pps_flag_o  <= 1'b0;
            armed_o     <= 1'b0;
            running_o   <= 1'b0;
            sec_count_o <= 32'd0;
        end else begin
            pps_o      <= pps_next;
            pps_flag_o <= load || wrap;
            armed_o    <= (state_next == WAIT_SYNC);
            running_o  <= (state_next == RUN);
            if (load) begin
                sec_count_o <= 32'd1;
            end else if (start_accept) begin
                sec_count_o <= 32'd0;
            end else if (wrap) begin
                sec_count_o <= sec_count_o + 32'd1;
            end else begin
                sec_count_o <= sec_count_o;
            end
        end
    end

endmodule

// File: tb/tb_pps_gen.sv
// -----------------------------------------------------------------------------
// tb_pps_gen
// Directed, table-driven bench for pps_gen with CLK_FREQ=100, DEFAULT_WIDTH=10.
// Each table record idles for 'delay' cycles, applies one cycle of stimulus
// and then compares all outputs against hand-computed values.
// Stimulus bits: {start, stop, align, sync, width_wr}
// Expected bits: {pps, flag, armed, running}
// -----------------------------------------------------------------------------
module tb_pps_gen;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              align = 1'b0;
    logic              sync = 1'b0;
    logic [23:0]       width = 24'd0;
    logic              width_wr = 1'b0;
    logic signed [7:0] trim = 8'sd0;
    logic              trim_wr = 1'b0;
    logic              pps;
    logic              pps_flag;
    logic              armed;
    logic              running;
    logic [31:0]       sec_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          delay;
        logic [4:0]  stim;
        logic [23:0] width;
        logic [3:0]  exp;
        logic [31:0] sec;
    } vec_t;

    vec_t vq[$];

    pps_gen #(
        .CLK_FREQ      (100),
        .CNT_BITS      (32),
        .WIDTH_BITS    (24),
        .DEFAULT_WIDTH (10)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .stop_i      (stop),
        .align_i     (align),
        .sync_i      (sync),
        .width_i     (width),
        .width_wr_i  (width_wr),
        .trim_i      (trim),
        .trim_wr_i   (trim_wr),
        .pps_o       (pps),
        .pps_flag_o  (pps_flag),
        .armed_o     (armed),
        .running_o   (running),
        .sec_count_o (sec_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [3:0] exp, input logic [31:0] sec);
        check({name, ".pps"},     32'(pps),      32'(exp[3]));
        check({name, ".flag"},    32'(pps_flag), 32'(exp[2]));
        check({name, ".armed"},   32'(armed),    32'(exp[1]));
        check({name, ".running"}, 32'(running),  32'(exp[0]));
        check({name, ".sec"},     sec_count,     sec);
    endtask

    task automatic add(input int d, input logic [4:0] s, input logic [23:0] w,
                       input logic [3:0] e, input logic [31:0] sec);
        vec_t v;
        v.delay = d;
        v.stim  = s;
        v.width = w;
        v.exp   = e;
        v.sec   = sec;
        vq.push_back(v);
    endtask

    // Counts cycles until the next pps_flag, bounded.
    task automatic wait_flag(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!pps_flag && n < 300);
    endtask

    initial begin
        int n;

        // Free-run: entry, 10-wide pulse, 100-clock period
        add( 4, 5'b10000, 24'd0,   4'b1101, 32'd1);  // cnt 0
        add( 0, 5'b00000, 24'd0,   4'b1001, 32'd1);  // cnt 1
        add( 7, 5'b00000, 24'd0,   4'b1001, 32'd1);  // cnt 9
        add( 0, 5'b00000, 24'd0,   4'b0001, 32'd1);  // cnt 10
        add(88, 5'b00000, 24'd0,   4'b0001, 32'd1);  // cnt 99
        add( 0, 5'b00000, 24'd0,   4'b1101, 32'd2);  // wrap
        add( 0, 5'b00000, 24'd0,   4'b1001, 32'd2);
        // Width 30 written mid-pulse: current pulse stays 10
        add( 3, 5'b00001, 24'd30,  4'b1001, 32'd2);  // cnt 5
        add( 3, 5'b00000, 24'd0,   4'b1001, 32'd2);  // cnt 9
        add( 0, 5'b00000, 24'd0,   4'b0001, 32'd2);  // cnt 10
        add(88, 5'b00000, 24'd0,   4'b0001, 32'd2);  // cnt 99
        add( 0, 5'b00000, 24'd0,   4'b1101, 32'd3);  // wrap, width 30
        add(28, 5'b00000, 24'd0,   4'b1001, 32'd3);  // cnt 29
        add( 0, 5'b00000, 24'd0,   4'b0001, 32'd3);  // cnt 30
        // Width 200: clamped to 99 high, 1 low
        add( 0, 5'b00001, 24'd200, 4'b0001, 32'd3);  // cnt 31
        add(67, 5'b00000, 24'd0,   4'b0001, 32'd3);  // cnt 99
        add( 0, 5'b00000, 24'd0,   4'b1101, 32'd4);  // wrap
        add(97, 5'b00000, 24'd0,   4'b1001, 32'd4);  // cnt 98
        add( 0, 5'b00000, 24'd0,   4'b0001, 32'd4);  // cnt 99
        // Width 0 written on the wrap edge: not used for this second
        add( 0, 5'b00001, 24'd0,   4'b1101, 32'd5);
        add(97, 5'b00000, 24'd0,   4'b1001, 32'd5);  // cnt 98
        add( 0, 5'b00000, 24'd0,   4'b0001, 32'd5);  // cnt 99
        add( 0, 5'b00000, 24'd0,   4'b0101, 32'd6);  // wrap, no pulse
        add( 0, 5'b00001, 24'd10,  4'b0001, 32'd6);  // cnt 1
        add(97, 5'b00000, 24'd0,   4'b0001, 32'd6);  // cnt 99
        add( 0, 5'b00000, 24'd0,   4'b1101, 32'd7);  // wrap, width 10
        // Stop mid-pulse, then start+stop together, sync in IDLE
        add( 2, 5'b01000, 24'd0,   4'b0000, 32'd7);
        add( 2, 5'b11000, 24'd0,   4'b0000, 32'd7);
        add( 0, 5'b00011, 24'd50,  4'b0000, 32'd7);
        // Aligned start
        add( 3, 5'b10100, 24'd0,   4'b0010, 32'd0);
        add(33, 5'b00100, 24'd0,   4'b0010, 32'd0);
        add( 0, 5'b10000, 24'd0,   4'b0010, 32'd0);  // start ignored
        add( 0, 5'b00010, 24'd0,   4'b1101, 32'd1);  // sync -> RUN, width 50
        add( 3, 5'b00010, 24'd0,   4'b1001, 32'd1);  // sync ignored, cnt 4
        add( 0, 5'b10000, 24'd0,   4'b1001, 32'd1);  // start ignored, cnt 5
        add(43, 5'b00000, 24'd0,   4'b1001, 32'd1);  // cnt 49
        add( 0, 5'b00000, 24'd0,   4'b0001, 32'd1);  // cnt 50
        add(48, 5'b00000, 24'd0,   4'b0001, 32'd1);  // cnt 99
        add( 0, 5'b00000, 24'd0,   4'b1101, 32'd2);  // wrap

        // Reset state
        tick();
        tick();
        check_all("reset", 4'b0000, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            repeat (vq[i].delay) tick();
            {start, stop, align, sync, width_wr} = vq[i].stim;
            width = vq[i].width;
            tick();
            start    = 1'b0;
            stop     = 1'b0;
            sync     = 1'b0;
            width_wr = 1'b0;
            check_all($sformatf("vec%0d", i), vq[i].exp, vq[i].sec);
        end

        // Asynchronous reset mid-pulse
        align = 1'b0;
        repeat (3) tick();
        check("rst_pre_pps", 32'(pps), 32'd1);
        #2 rst = 1'b1;
        #1 check_all("rst_async", 4'b0000, 32'd0);
        tick();
        rst = 1'b0;

        // Width reverts to the default after reset
        start = 1'b1;
        tick();
        start = 1'b0;
        check_all("restart", 4'b1101, 32'd1);
        repeat (9) tick();
        check("def_width_cnt9", 32'(pps), 32'd1);
        tick();
        check("def_width_cnt10", 32'(pps), 32'd0);

        // One-shot trim written during second 1
        trim    = -8'sd5;
        trim_wr = 1'b1;
        tick();
        trim_wr = 1'b0;
        wait_flag(n);
        check("sec1_rest", n, 32'd89);
        wait_flag(n);
`ifdef PPS_GEN_TRIM_EN
        check("sec2_len", n, 32'd95);
`else
        check("sec2_len", n, 32'd100);
`endif
        wait_flag(n);
        check("sec3_len", n, 32'd100);
        check("sec_after_trim", sec_count, 32'd4);

        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_all("final_stop", 4'b0000, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pps_gen.md
Name: pps_gen

Overview:
- Transmit-side counterpart to the PPS receive/holdoff path: generates a local PPS output pulse train from a single clock.
- Programmable pulse width; runs free, or arms and aligns its first edge to an incoming PPS flag (e.g. from the PPS receiver).
- Drives the board PPS output pin and an internal one-cycle flag, and counts seconds for timestamping logic.

Parameters:
- CLK_FREQ, 100000000, clocks per second; nominal period.
- CNT_BITS, 32, counter width; CLK_FREQ+128 must be < 2^CNT_BITS.
- WIDTH_BITS, 24, width of pulse-width register.
- DEFAULT_WIDTH, 10000000, pulse width in clocks after reset.

Ports:
- clk_i  in  1  single clock; all logic in this domain.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  one-cycle start request.
- stop_i  in  1  one-cycle stop request.
- align_i  in  1  level; if high at start, wait for sync_i before running.
- sync_i  in  1  one-cycle external PPS flag (already in clk_i domain).
- width_i  in  WIDTH_BITS  new pulse width, clocks.
- width_wr_i  in  1  write strobe for width_i.
- trim_i  in  8  signed period trim, clocks (optional feature).
- trim_wr_i  in  1  write strobe for trim_i (optional feature).
- pps_o  out  1  registered PPS output pulse.
- pps_flag_o  out  1  one-cycle flag on each pps_o rising edge.
- armed_o  out  1  high while waiting for sync_i.
- running_o  out  1  high while generating.
- sec_count_o  out  32  seconds generated since last start.

Behaviour:
- Reset:
  - state=IDLE; cnt=0.
  - pps_o, pps_flag_o, armed_o, running_o = 0; sec_count_o=0.
  - width_act and width_shadow = DEFAULT_WIDTH; trim pending cleared.
- States:
  - IDLE: start_i with align_i=0 -> RUN; start_i with align_i=1 -> WAIT_SYNC.
  - WAIT_SYNC: sync_i -> RUN.
  - RUN: on cnt==period-1, cnt wraps to 0.
  - stop_i in any state -> IDLE.
- Entering RUN (edge E):
  - cnt=0, sec_count_o=1, pps_flag_o=1.
  - pps_o=1 after edge E if width_act>0, giving 1-cycle latency from start_i or sync_i.
  - sec_count_o cleared to 0 on any start_i accepted from IDLE.
- RUN output: pps_o is registered alongside cnt; high exactly while cnt < width_act.
- At each wrap to 0:
  - pps_flag_o pulses.
  - sec_count_o increments; wraps at 2^32 silently.
  - width_shadow copies to width_act.
- Period is CLK_FREQ, plus pending trim if enabled.
- width_wr_i:
  - Loads width_shadow immediately; width_act updates only at the next wrap (or on RUN entry), so no runt or stretched pulse.
  - Writes in IDLE apply at start.
- Width clamp:
  - width_act=0 -> pps_o never asserts, but pps_flag_o and sec_count still run.
  - width_act >= period -> pulse truncated to period-1, guaranteeing at least 1 low cycle per second.
- stop_i:
  - Next edge: pps_o=0 (truncating any active pulse), cnt=0, running_o=0, armed_o=0.
  - sec_count_o holds.
- Simultaneous events:
  - stop_i and start_i together: stop wins.
  - start_i in RUN or WAIT_SYNC: ignored.
  - sync_i in IDLE or RUN: ignored.
  - width_wr_i at the same edge as a wrap: the new value is NOT used for that second.
- armed_o = (state==WAIT_SYNC); running_o = (state==RUN); both registered.
- Async reset mid-pulse: pps_o drops immediately.

Optional Feature:
- Macro: PPS_GEN_TRIM_EN.
- Defined:
  - trim_wr_i latches trim_i (signed, -128..127) as pending.
  - The next full second after the following wrap has period CLK_FREQ+trim; the trim is then consumed (one-shot), so the second after returns to CLK_FREQ.
  - A second write before consumption overwrites the pending value.
  - stop_i clears the pending trim.
- Undefined: trim_i and trim_wr_i are ignored; period is always CLK_FREQ.

Decomposition:
- pps_gen_pkg holds:
  - state enum (IDLE, WAIT_SYNC, RUN).
  - TRIM_BITS=8 constant.
  - helper function computing the clamped width.
- One sub-module, pps_period_counter: cnt, period/trim selection and the wrap strobe; the FSM and output registers remain in pps_gen.

Test Plan (CLK_FREQ=100, DEFAULT_WIDTH=10):
- Free-run: start_i, align_i=0 at cycle 5 -> pps_o high cycles 6-15, low 16-105, high again at 106; pps_flag_o at 6 and 106; sec_count_o=1, then 2.
- Aligned: align_i=1, start_i at 5, sync_i at 40 -> armed_o high 6-40; pps_o rises at 41; no pulse before.
- Width change: width_wr_i width_i=30 at cnt=5 -> current pulse stays 10 wide; next second 30 wide. width_i=200 -> 99 high, 1 low. width_i=0 -> pps_o stays low, flags continue.
- Stop and simultaneous: stop_i at cnt=3 -> pps_o low next cycle, state IDLE. start_i and stop_i in the same cycle -> remains IDLE.
- Reset: rst_i asserted mid-pulse -> pps_o low with no clock edge; all outputs zero; width back to 10.
- Trim (PPS_GEN_TRIM_EN): trim_i=-5 written in second 1 -> second 2 lasts 95 clocks, second 3 lasts 100. Without the macro, all seconds last 100.
